// File: rtl/keysw_io.sv
`default_nettype none
//==============================================================================
// Module  : keysw_io
// Desc    : Debounced KEY/SW memory-mapped input device with sticky status/IRQ
// Rev     : 1.0
//==============================================================================

module keysw_io_debounce #(
    parameter int W              = 4,
    parameter int DEBOUNCECYCLES = 500000,
    parameter int CNTBITS        = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] stable_o,
    output logic         accept_o
);
    // A new value is accepted after DEBOUNCECYCLES+1 consecutive matching
    // sync2/sync2_dly compares, so stable moves DEBOUNCECYCLES+3 edges after
    // the raw change.
    localparam logic [CNTBITS-1:0] C_ACCEPT_CNT = CNTBITS'(DEBOUNCECYCLES);

    logic [W-1:0]       sync1_q;
    logic [W-1:0]       sync2_q;
    logic [W-1:0]       sync2_dly_q;
    logic [W-1:0]       stable_q;
    logic [W-1:0]       stable_d;
    logic [CNTBITS-1:0] cnt_q;
    logic [CNTBITS-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync2_dly_q <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        if (sync2_q != sync2_dly_q) begin
            cnt_d = '0;
        end else if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_ACCEPT_CNT) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            accept_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CNTBITS'(1);
        end
    end

    assign stable_o = stable_q;
endmodule

module keysw_io #(
    parameter int               DBITS          = 32,
    parameter logic [DBITS-1:0] ADDRKEY        = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRSW         = 32'hFFFFF090,
    parameter int               DEBOUNCECYCLES = 500000,
    parameter int               CNTBITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrdata,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [DBITS-1:0] rddata,
    output logic             sel,
    output logic             intr
);
    localparam logic [DBITS-1:0] C_KDATA = ADDRKEY;
    localparam logic [DBITS-1:0] C_KCTRL = ADDRKEY + DBITS'(4);
    localparam logic [DBITS-1:0] C_SDATA = ADDRSW;
    localparam logic [DBITS-1:0] C_SCTRL = ADDRSW + DBITS'(4);

    logic [3:0] w_key_raw;
    logic [3:0] w_key_stable;
    logic       w_key_acc;
    logic [9:0] w_sw_stable;
    logic       w_sw_acc;
    logic       w_kdata_rd, w_kctrl_wr, w_sdata_rd, w_sctrl_wr;
    logic       w_unused_wrdata;

    logic kready_q, kready_d, kovr_q, kovr_d, kie_q, kie_d;
    logic sready_q, sready_d, sovr_q, sovr_d, sie_q, sie_d;

    assign w_key_raw = ~KEY;

    keysw_io_debounce #(.W(4), .DEBOUNCECYCLES(DEBOUNCECYCLES), .CNTBITS(CNTBITS)) u_key_db (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (w_key_raw),
        .stable_o (w_key_stable),
        .accept_o (w_key_acc)
    );

    keysw_io_debounce #(.W(10), .DEBOUNCECYCLES(DEBOUNCECYCLES), .CNTBITS(CNTBITS)) u_sw_db (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (SW),
        .stable_o (w_sw_stable),
        .accept_o (w_sw_acc)
    );

    assign w_kdata_rd = re && (addr == C_KDATA);
    assign w_kctrl_wr = we && (addr == C_KCTRL);
    assign w_sdata_rd = re && (addr == C_SDATA);
    assign w_sctrl_wr = we && (addr == C_SCTRL);
    assign w_unused_wrdata = ^{wrdata[DBITS-1:9], wrdata[7:3], wrdata[1:0]};

    // Overrun set is applied after the write-clear so a same-cycle set wins.
    always_comb begin
        kovr_d = kovr_q;
        if (w_kctrl_wr && !wrdata[2]) kovr_d = 1'b0;
        if (w_key_acc && kready_q && !w_kdata_rd) kovr_d = 1'b1;
        kready_d = w_key_acc | (kready_q & ~w_kdata_rd);
        kie_d    = w_kctrl_wr ? wrdata[8] : kie_q;

        sovr_d = sovr_q;
        if (w_sctrl_wr && !wrdata[2]) sovr_d = 1'b0;
        if (w_sw_acc && sready_q && !w_sdata_rd) sovr_d = 1'b1;
        sready_d = w_sw_acc | (sready_q & ~w_sdata_rd);
        sie_d    = w_sctrl_wr ? wrdata[8] : sie_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kready_q <= 1'b0;
            kovr_q   <= 1'b0;
            kie_q    <= 1'b0;
            sready_q <= 1'b0;
            sovr_q   <= 1'b0;
            sie_q    <= 1'b0;
        end else begin
            kready_q <= kready_d;
            kovr_q   <= kovr_d;
            kie_q    <= kie_d;
            sready_q <= sready_d;
            sovr_q   <= sovr_d;
            sie_q    <= sie_d;
        end
    end

    always_comb begin
        rddata = '0;
        sel    = 1'b0;
        if (addr == C_KDATA) begin
            sel         = 1'b1;
            rddata[3:0] = w_key_stable;
        end else if (addr == C_KCTRL) begin
            sel       = 1'b1;
            rddata[0] = kready_q;
            rddata[2] = kovr_q;
            rddata[8] = kie_q;
        end else if (addr == C_SDATA) begin
            sel         = 1'b1;
            rddata[9:0] = w_sw_stable;
        end else if (addr == C_SCTRL) begin
            sel       = 1'b1;
            rddata[0] = sready_q;
            rddata[2] = sovr_q;
            rddata[8] = sie_q;
        end
    end

    assign intr = (kready_q & kie_q) | (sready_q & sie_q);
endmodule
`default_nettype wire

// File: tb/tb_keysw_io.sv
`default_nettype none
//==============================================================================
// Module  : tb_keysw_io
// Desc    : Directed + randomized self-checking bench for keysw_io
// Rev     : 1.0
//==============================================================================
module tb_keysw_io;
    localparam int          DEB = 4;
    localparam logic [31:0] AK  = 32'hFFFFF080;
    localparam logic [31:0] AKC = 32'hFFFFF084;
    localparam logic [31:0] AS  = 32'hFFFFF090;
    localparam logic [31:0] ASC = 32'hFFFFF094;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] addr   = 32'd0;
    logic [31:0] wrdata = 32'd0;
    logic        we     = 1'b0;
    logic        re     = 1'b0;
    logic [3:0]  KEY    = 4'hF;
    logic [9:0]  SW     = 10'd0;
    logic [31:0] rddata;
    logic        sel;
    logic        intr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: accepted values, status bits, and the history of
    // raw samples taken at each edge (index 0 = most recent edge).
    logic [3:0] mk_stable;
    logic       mk_ready, mk_ovr, mk_ie;
    logic [9:0] ms_stable;
    logic       ms_ready, ms_ovr, ms_ie;
    logic [3:0] hk [0:DEB+2];
    logic [9:0] hs [0:DEB+2];

    logic [3:0]  rk;
    logic [9:0]  rs;
    logic [31:0] ra;

    keysw_io #(.DEBOUNCECYCLES(DEB), .CNTBITS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wrdata (wrdata),
        .we     (we),
        .re     (re),
        .KEY    (KEY),
        .SW     (SW),
        .rddata (rddata),
        .sel    (sel),
        .intr   (intr)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        case (a)
            AK:      return {28'd0, mk_stable};
            AKC:     return {23'd0, mk_ie, 5'd0, mk_ovr, 1'b0, mk_ready};
            AS:      return {22'd0, ms_stable};
            ASC:     return {23'd0, ms_ie, 5'd0, ms_ovr, 1'b0, ms_ready};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_sel(input logic [31:0] a);
        return (a == AK) || (a == AKC) || (a == AS) || (a == ASC);
    endfunction

    task automatic model_reset();
        mk_stable = '0; mk_ready = 1'b0; mk_ovr = 1'b0; mk_ie = 1'b0;
        ms_stable = '0; ms_ready = 1'b0; ms_ovr = 1'b0; ms_ie = 1'b0;
        for (int i = 0; i <= DEB + 2; i++) begin
            hk[i] = '0;
            hs[i] = '0;
        end
    endtask

    // A value is accepted at an edge once the synchronized input has shown
    // the same, different-from-stable value for DEB+2 consecutive cycles.
    task automatic model_edge(input logic [31:0] a, input logic r, input logic w,
                              input logic [31:0] wd, input logic [3:0] kraw,
                              input logic [9:0] sraw);
        logic ka, sa, krd, srd, kwc, swc, kset, sset;
        ka = (hk[1] != mk_stable);
        sa = (hs[1] != ms_stable);
        for (int i = 2; i <= DEB + 2; i++) begin
            if (hk[i] != hk[1]) ka = 1'b0;
            if (hs[i] != hs[1]) sa = 1'b0;
        end
        krd  = r && (a == AK);
        srd  = r && (a == AS);
        kwc  = w && (a == AKC);
        swc  = w && (a == ASC);
        kset = ka && mk_ready && !krd;
        sset = sa && ms_ready && !srd;
        if (kwc) begin
            mk_ie = wd[8];
            if (!wd[2]) mk_ovr = 1'b0;
        end
        if (swc) begin
            ms_ie = wd[8];
            if (!wd[2]) ms_ovr = 1'b0;
        end
        if (kset) mk_ovr = 1'b1;
        if (sset) ms_ovr = 1'b1;
        if (ka) begin
            mk_ready  = 1'b1;
            mk_stable = hk[1];
        end else if (krd) begin
            mk_ready = 1'b0;
        end
        if (sa) begin
            ms_ready  = 1'b1;
            ms_stable = hs[1];
        end else if (srd) begin
            ms_ready = 1'b0;
        end
        for (int i = DEB + 2; i > 0; i--) begin
            hk[i] = hk[i-1];
            hs[i] = hs[i-1];
        end
        hk[0] = kraw;
        hs[0] = sraw;
    endtask

    task automatic step(input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] wd, input logic [3:0] k, input logic [9:0] s);
        addr = a; re = r; we = w; wrdata = wd; KEY = k; SW = s;
        #1;
        chk("rddata", rddata, exp_rd(a));
        chk("sel", {31'd0, sel}, {31'd0, exp_sel(a)});
        chk("intr", {31'd0, intr}, {31'd0, (mk_ready & mk_ie) | (ms_ready & ms_ie)});
        @(posedge clk);
        model_edge(a, r, w, wd, ~k, s);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [3:0] k, input logic [9:0] s);
        repeat (n) step(32'd0, 1'b0, 1'b0, 32'd0, k, s);
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a; re = 1'b0; we = 1'b0;
        #1;
        chk(tag, rddata, exp);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        peek(AK, 32'd0, "rst_kdata");
        peek(AKC, 32'd0, "rst_kctrl");
        peek(AS, 32'd0, "rst_sdata");
        peek(ASC, 32'd0, "rst_sctrl");
        peek(AK + 32'd8, 32'd0, "rst_hole_rd");
        chk("rst_hole_sel", {31'd0, sel}, 32'd0);
        chk("rst_intr", {31'd0, intr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Key press latency: visible after edge 7, not edge 6.
        idle(7, 4'hE, 10'd0);
        peek(AK, 32'd0, "key_e6");
        idle(1, 4'hE, 10'd0);
        peek(AK, 32'd1, "key_e7");
        peek(AKC, 32'd1, "kctrl_e7");
        step(AK, 1'b1, 1'b0, 32'd0, 4'hE, 10'd0);
        peek(AKC, 32'd0, "kctrl_after_rd");

        // Switch glitch rejected, long hold accepted.
        idle(3, 4'hE, 10'd1);
        idle(10, 4'hE, 10'd0);
        peek(AS, 32'd0, "glitch_sdata");
        peek(ASC, 32'd0, "glitch_sctrl");
        idle(10, 4'hE, 10'd1);
        peek(AS, 32'd1, "hold_sdata");

        // Overrun set, clear by write, then accept coinciding with a data read.
        idle(10, 4'hC, 10'd1);
        idle(10, 4'h8, 10'd1);
        peek(AKC, 32'h5, "ovr_set");
        step(AKC, 1'b0, 1'b1, 32'd0, 4'h8, 10'd1);
        peek(AKC, 32'h1, "ovr_clr");
        idle(7, 4'h0, 10'd1);
        step(AK, 1'b1, 1'b0, 32'd0, 4'h0, 10'd1);
        peek(AKC, 32'h1, "acc_rd_kctrl");
        peek(AK, 32'hF, "acc_rd_kdata");

        // Switch interrupt.
        step(AS, 1'b1, 1'b0, 32'd0, 4'h0, 10'd1);
        step(ASC, 1'b0, 1'b1, 32'h100, 4'h0, 10'd1);
        idle(7, 4'h0, 10'd3);
        chk("intr_e6", {31'd0, intr}, 32'd0);
        idle(1, 4'h0, 10'd3);
        chk("intr_e7", {31'd0, intr}, 32'd1);
        step(AS, 1'b1, 1'b0, 32'd0, 4'h0, 10'd3);
        chk("intr_rd", {31'd0, intr}, 32'd0);

        // Asynchronous reset in the middle of a debounce count.
        idle(5, 4'h0, 10'h3FF);
        #2 reset = 1'b1;
        peek(AS, 32'd0, "arst_sdata");
        peek(ASC, 32'd0, "arst_sctrl");
        peek(AKC, 32'd0, "arst_kctrl");
        chk("arst_intr", {31'd0, intr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(7, 4'h0, 10'h3FF);
        peek(AS, 32'd0, "arst_e6");
        idle(1, 4'h0, 10'h3FF);
        peek(AS, 32'h3FF, "arst_e7");

        // Randomized traffic against the reference model.
        rk = 4'h0;
        rs = 10'h3FF;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rk = rk ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rs = rs ^ 10'(1 << $urandom_range(0, 9));
            case ($urandom_range(0, 5))
                0:       ra = AK;
                1:       ra = AKC;
                2:       ra = AS;
                3:       ra = ASC;
                4:       ra = AK + 32'd8;
                default: ra = $urandom;
            endcase
            step(ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom, rk, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
